// File: rtl/mem_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// mem_hazard_ctrl
//
// Pipeline sequencing controller for the 6-stage MIPS core
// (IF, ID, EX, MEM1, MEM2, WB).
//   * Detects load-use hazards against the EX and MEM1 stages and inserts
//     bubbles into ID/EX while holding the front end.
//   * Runs the data-SRAM request/ready handshake for MEM1 and freezes the
//     whole pipeline during wait states, with a timeout abort after MAX_WAIT
//     consecutive wait cycles (sticky mem_err).
//   * Generates branch flushes and keeps saturating stall counters.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   src1, src2        ID-stage source registers; two_src = src2 is read
//   ex_dest           EX-stage destination; ex_mem_r_en = EX holds a load
//   mem1_dest         MEM1-stage destination
//   mem1_mem_r_en/_w_en  MEM1 holds a load / store
//   branch_taken      branch resolved taken in EX
//   dmem_ready        data SRAM completes the current access this cycle
//   dmem_req          data SRAM access request
//   freeze_front      hold PC and IF/ID
//   bubble_ex         load zeros into ID/EX control bits
//   freeze_all        hold every pipeline register (PC through MEM2/WB)
//   flush_front       zero IF/ID and ID/EX
//   mem_err           sticky dmem timeout flag
//   hazard_cnt        saturating count of bubble cycles
//   memwait_cnt       saturating count of memory wait cycles
// ---------------------------------------------------------------------------
module mem_hazard_ctrl #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       src1,
  input  logic [4:0]       src2,
  input  logic             two_src,
  input  logic [4:0]       ex_dest,
  input  logic             ex_mem_r_en,
  input  logic [4:0]       mem1_dest,
  input  logic             mem1_mem_r_en,
  input  logic             mem1_mem_w_en,
  input  logic             branch_taken,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             freeze_front,
  output logic             bubble_ex,
  output logic             freeze_all,
  output logic             flush_front,
  output logic             mem_err,
  output logic [CNT_W-1:0] hazard_cnt,
  output logic [CNT_W-1:0] memwait_cnt
);

  localparam int WC_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [WC_W-1:0]   wait_q, wait_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  hcnt_q, hcnt_d;
  logic [CNT_W-1:0]  mcnt_q, mcnt_d;

  logic access;
  logic hazard;
  logic wait_max;
  logic mem_stall;

  // Register 0 is hard-wired, so a write to it never creates a dependency.
  function automatic logic hit(input logic [4:0] d, input logic [4:0] s1,
                               input logic [4:0] s2, input logic two);
    return (d != 5'd0) && ((s1 == d) || (two && (s2 == d)));
  endfunction

  // Saturating increment: sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic en);
    if (en && (v != {CNT_W{1'b1}}))
      return v + CNT_W'(1);
    else
      return v;
  endfunction

  assign access   = mem1_mem_r_en | mem1_mem_w_en;
  assign hazard   = (ex_mem_r_en   & hit(ex_dest,   src1, src2, two_src)) |
                    (mem1_mem_r_en & hit(mem1_dest, src1, src2, two_src));
  assign wait_max = (state_q == BUSY) && (wait_q == WC_W'(MAX_WAIT));
  // On the timeout cycle the stall is dropped so the pipeline moves on.
  assign mem_stall = access & ~dmem_ready & ~wait_max;

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    err_d        = err_q;
    dmem_req     = 1'b0;
    freeze_front = 1'b0;
    bubble_ex    = 1'b0;
    freeze_all   = 1'b0;
    flush_front  = 1'b0;

    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          dmem_req = access;
          // A zero-wait access completes in place and never enters BUSY.
          if (access && !dmem_ready) begin
            state_d = BUSY;
            wait_d  = WC_W'(1);
          end
        end
        BUSY: begin
          dmem_req = 1'b1;
          if (dmem_ready) begin
            state_d = IDLE;
            wait_d  = '0;
          end else if (wait_max) begin
            state_d = IDLE;
            wait_d  = '0;
            err_d   = 1'b1;
          end else begin
            wait_d = wait_q + WC_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          wait_d  = '0;
        end
      endcase

      // Priority: global freeze, then branch flush, then load-use bubble.
      freeze_all   = mem_stall;
      flush_front  = branch_taken & ~mem_stall;
      bubble_ex    = hazard & ~mem_stall & ~branch_taken;
      freeze_front = hazard & ~mem_stall & ~branch_taken;
    end
  end

  assign hcnt_d = sat_inc(hcnt_q, bubble_ex);
  assign mcnt_d = sat_inc(mcnt_q, freeze_all);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wait_q  <= '0;
      err_q   <= 1'b0;
      hcnt_q  <= '0;
      mcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      hcnt_q  <= hcnt_d;
      mcnt_q  <= mcnt_d;
    end
  end

  assign mem_err     = err_q;
  assign hazard_cnt  = hcnt_q;
  assign memwait_cnt = mcnt_q;

endmodule

// File: tb/tb_mem_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_hazard_ctrl
//
// Directed-vector bench. Each stimulus cycle pushes its hand-computed expected
// outputs into a scoreboard queue; a monitor on the falling edge pops and
// compares. Counters are 4 bits wide here so saturation is reachable.
// Expected vector layout: {dmem_req, freeze_front, bubble_ex, freeze_all,
// flush_front}.
// ---------------------------------------------------------------------------
module tb_mem_hazard_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    src1, src2, ex_dest, mem1_dest;
  logic          two_src, ex_mem_r_en, mem1_mem_r_en, mem1_mem_w_en;
  logic          branch_taken, dmem_ready;
  logic          dmem_req, freeze_front, bubble_ex, freeze_all, flush_front;
  logic          mem_err;
  logic [CW-1:0] hazard_cnt, memwait_cnt;

  mem_hazard_ctrl #(.MAX_WAIT(15), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .src1         (src1),
    .src2         (src2),
    .two_src      (two_src),
    .ex_dest      (ex_dest),
    .ex_mem_r_en  (ex_mem_r_en),
    .mem1_dest    (mem1_dest),
    .mem1_mem_r_en(mem1_mem_r_en),
    .mem1_mem_w_en(mem1_mem_w_en),
    .branch_taken (branch_taken),
    .dmem_ready   (dmem_ready),
    .dmem_req     (dmem_req),
    .freeze_front (freeze_front),
    .bubble_ex    (bubble_ex),
    .freeze_all   (freeze_all),
    .flush_front  (flush_front),
    .mem_err      (mem_err),
    .hazard_cnt   (hazard_cnt),
    .memwait_cnt  (memwait_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] outs;
    logic       err;
    int         hc;
    int         mc;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Monitor: compare on the falling edge, well away from the active edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [4:0] act;
      e   = sb.pop_front();
      act = {dmem_req, freeze_front, bubble_ex, freeze_all, flush_front};
      n_checks++;
      if (act !== e.outs) begin
        n_errors++;
        $display("FAIL %s outs(req,ff,bub,fa,fl): got %b expected %b", e.name, act, e.outs);
      end
      n_checks++;
      if (mem_err !== e.err) begin
        n_errors++;
        $display("FAIL %s mem_err: got %b expected %b", e.name, mem_err, e.err);
      end
      n_checks++;
      if (hazard_cnt !== CW'(e.hc)) begin
        n_errors++;
        $display("FAIL %s hazard_cnt: got %0d expected %0d", e.name, hazard_cnt, e.hc);
      end
      n_checks++;
      if (memwait_cnt !== CW'(e.mc)) begin
        n_errors++;
        $display("FAIL %s memwait_cnt: got %0d expected %0d", e.name, memwait_cnt, e.mc);
      end
    end
  end

  // One stimulus cycle: drive just after the rising edge, queue expectations.
  task automatic cyc(input logic r, input logic [4:0] s1, input logic [4:0] s2,
                     input logic two, input logic [4:0] exd, input logic exr,
                     input logic [4:0] m1d, input logic m1r, input logic m1w,
                     input logic br, input logic rdy,
                     input logic [4:0] eo, input logic ee, input int eh,
                     input int em, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; src1 = s1; src2 = s2; two_src = two; ex_dest = exd;
    ex_mem_r_en = exr; mem1_dest = m1d; mem1_mem_r_en = m1r;
    mem1_mem_w_en = m1w; branch_taken = br; dmem_ready = rdy;
    e.outs = eo; e.err = ee; e.hc = eh; e.mc = em; e.name = nm;
    sb.push_back(e);
  endtask

  initial begin
    rst = 1'b1; src1 = '0; src2 = '0; two_src = 1'b0; ex_dest = '0;
    ex_mem_r_en = 1'b0; mem1_dest = '0; mem1_mem_r_en = 1'b0;
    mem1_mem_w_en = 1'b0; branch_taken = 1'b0; dmem_ready = 1'b1;

    //  r  s1 s2 2s exd exr m1d m1r m1w br rdy  outs    err hc mc name
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b00000, 0, 0, 0, "reset0");
    cyc(1, 5, 0, 0, 5, 1, 0, 0, 1, 1, 0, 5'b00000, 0, 0, 0, "reset_gated");

    // Load-use at distance 1: two bubbles.
    cyc(0, 5, 0, 0, 5, 1, 0, 0, 0, 0, 1, 5'b01100, 0, 0, 0, "lu_ex");
    cyc(0, 5, 0, 0, 0, 0, 5, 1, 0, 0, 1, 5'b11100, 0, 1, 0, "lu_mem1");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b00000, 0, 2, 0, "lu_done");

    // Register 0 and single-source reads never hazard.
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 5'b00000, 0, 2, 0, "r0_nohit");
    cyc(0, 0, 7, 0, 7, 1, 0, 0, 0, 0, 1, 5'b00000, 0, 2, 0, "src2_unused");
    cyc(0, 0, 7, 1, 7, 1, 0, 0, 0, 0, 1, 5'b01100, 0, 2, 0, "src2_used");
    cyc(0, 0, 9, 1, 0, 0, 9, 1, 0, 0, 1, 5'b11100, 0, 3, 0, "mem1_src2");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b00000, 0, 4, 0, "idle_a");

    // Store with three wait cycles.
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b10010, 0, 4, 0, "wait1");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b10010, 0, 4, 1, "wait2");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b10010, 0, 4, 2, "wait3");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 5'b10000, 0, 4, 3, "wait_ready");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b00000, 0, 4, 3, "wait_idle");

    // Back-to-back zero-wait loads.
    cyc(0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 1, 5'b10000, 0, 4, 3, "zw_load1");
    cyc(0, 0, 0, 0, 0, 0, 4, 1, 0, 0, 1, 5'b10000, 0, 4, 3, "zw_load2");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b00000, 0, 4, 3, "zw_idle");

    // Branch beats hazard; freeze beats branch.
    cyc(0, 6, 0, 0, 6, 1, 0, 0, 0, 1, 1, 5'b00001, 0, 4, 3, "br_vs_hazard");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b00000, 0, 4, 3, "br_idle");
    cyc(0, 2, 0, 0, 0, 0, 2, 1, 0, 1, 0, 5'b10010, 0, 4, 3, "br_in_wait");
    cyc(0, 2, 0, 0, 0, 0, 2, 1, 0, 1, 1, 5'b10001, 0, 4, 4, "br_at_ready");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b00000, 0, 4, 4, "br_idle2");

    // Timeout: 15 frozen cycles, released on the 16th, memwait saturates at 15.
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 5'b10010, 0, 4, 4, "to_first");
    for (int i = 1; i <= 14; i++)
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 5'b10010, 0, 4,
          ((4 + i) > 15) ? 15 : (4 + i), "to_wait");
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 5'b10000, 0, 4, 15, "to_release");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b00000, 1, 4, 15, "to_err");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b00000, 1, 4, 15, "err_sticky");

    // Reset in the middle of a BUSY wait.
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b10010, 1, 4, 15, "rb_wait1");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b10010, 1, 4, 15, "rb_wait2");
    cyc(1, 3, 0, 0, 3, 1, 0, 0, 1, 1, 0, 5'b00000, 1, 4, 15, "rb_rst");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b00000, 0, 0, 0, "rb_cleared");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 5'b10000, 0, 0, 0, "rb_zero_wait");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b00000, 0, 0, 0, "final_idle");

    // Let the monitor drain the queue, bounded.
    for (int k = 0; k < 20 && sb.size() > 0; k++)
      @(posedge clk);
    if (sb.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
